// File: rtl/fwd_pkg.sv
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and helpers for the forwarding / hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    // Widest register index the shadow entry can hold; narrower indices are zero-extended.
    localparam int c_RD_MAX_W = 8;

    // Select value meaning "read the register file".
    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic                  wb;
        logic                  load;
        logic [c_RD_MAX_W-1:0] rd;
    } shadow_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module      : fwd_match
// Description : Youngest-match priority select over the shadow stages for one
//               source operand, plus its load-use hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = 2
) (
    input  logic [DEPTH*$bits(shadow_entry_t)-1:0] i_entries,
    input  logic [REG_W-1:0]                       i_rs,
    output logic [SEL_W-1:0]                       o_sel,
    output logic                                   o_load_hazard
);

    localparam int c_ENT_W = $bits(shadow_entry_t);

    shadow_entry_t         w_ent [DEPTH];
    logic [c_RD_MAX_W-1:0] w_rs_ext;

    assign w_rs_ext = c_RD_MAX_W'(i_rs);

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_unpack
            assign w_ent[g] = i_entries[g*c_ENT_W +: c_ENT_W];
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        o_sel         = SEL_W'(SEL_RF);
        o_load_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_ent[k].valid && w_ent[k].wb && (w_ent[k].rd != '0) &&
                (w_ent[k].rd == w_rs_ext)) begin
                o_sel         = SEL_W'(k + 1);
                o_load_hazard = w_ent[k].load && ((k + 1) < LOAD_LAT);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Shadow destination pipeline with per-operand forwarding select
//               and load-use stall. Optional macro FWD_STALL_CNT_EN adds a
//               saturating stall-cycle counter output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int REG_W    = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 2,
    localparam int SEL_W    = sel_w(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    input  logic [REG_W-1:0]         issue_rd_i,
    input  logic                     issue_wb_i,
    input  logic                     issue_load_i,
    input  logic [NUM_SRC*REG_W-1:0] rs_i,
    input  logic                     hold_i,
    input  logic                     flush_i,
    output logic [NUM_SRC*SEL_W-1:0] sel_o,
    output logic                     stall_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int c_ENT_W = $bits(shadow_entry_t);

    generate
        if (REG_W > c_RD_MAX_W) begin : g_chk_reg_w
            $error("REG_W exceeds shadow entry rd width");
        end
    endgenerate

    shadow_entry_t              r_stage [DEPTH];
    shadow_entry_t              w_issue;
    logic [DEPTH*c_ENT_W-1:0]   w_entries;
    logic [NUM_SRC-1:0]         w_haz;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign w_entries[g*c_ENT_W +: c_ENT_W] = r_stage[g];
        end

        for (g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_match #(
                .REG_W    (REG_W),
                .DEPTH    (DEPTH),
                .LOAD_LAT (LOAD_LAT),
                .SEL_W    (SEL_W)
            ) u_match (
                .i_entries     (w_entries),
                .i_rs          (rs_i[g*REG_W +: REG_W]),
                .o_sel         (sel_o[g*SEL_W +: SEL_W]),
                .o_load_hazard (w_haz[g])
            );
        end
    endgenerate

    assign stall_o = (|w_haz) && !flush_i;

    // A stalled issue is replaced by a bubble; the ID instruction retries.
    always_comb begin
        w_issue = '0;
        if (issue_valid_i && !stall_o) begin
            w_issue.valid = 1'b1;
            w_issue.wb    = issue_wb_i;
            w_issue.load  = issue_load_i;
            w_issue.rd    = c_RD_MAX_W'(issue_rd_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (!hold_i) begin
            for (int i = DEPTH - 1; i > 0; i--) r_stage[i] <= r_stage[i-1];
            r_stage[0] <= w_issue;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_o && !hold_i && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit with a list-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int REG_W    = 5;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     issue_valid_i;
    logic [REG_W-1:0]         issue_rd_i;
    logic                     issue_wb_i;
    logic                     issue_load_i;
    logic [NUM_SRC*REG_W-1:0] rs_i;
    logic                     hold_i;
    logic                     flush_i;
    logic [NUM_SRC*SEL_W-1:0] sel_o;
    logic                     stall_o;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]              stall_cnt_o;
`endif

    fwd_hazard_unit #(
        .REG_W    (REG_W),
        .NUM_SRC  (NUM_SRC),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_wb_i    (issue_wb_i),
        .issue_load_i  (issue_load_i),
        .rs_i          (rs_i),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .sel_o         (sel_o),
        .stall_o       (stall_o)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: list of in-flight instructions, index 1 = youngest stage.
    int          m_valid [1:DEPTH];
    int          m_wb    [1:DEPTH];
    int          m_load  [1:DEPTH];
    int          m_rd    [1:DEPTH];
    longint      m_cnt;
    int          exp_sel [NUM_SRC];
    int          exp_stall;

    int          obs_sel [NUM_SRC];
    int          obs_stall;
    longint      obs_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            m_valid[k] = 0; m_wb[k] = 0; m_load[k] = 0; m_rd[k] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_eval();
        exp_stall = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            int rs;
            rs = int'(rs_i[s*REG_W +: REG_W]);
            exp_sel[s] = 0;
            if (rs != 0) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    if (exp_sel[s] == 0 && m_valid[k] != 0 && m_wb[k] != 0 && m_rd[k] == rs) begin
                        exp_sel[s] = k;
                        if (m_load[k] != 0 && k < LOAD_LAT) exp_stall = 1;
                    end
                end
            end
        end
        if (flush_i) exp_stall = 0;
    endtask

    task automatic model_advance();
        if (exp_stall != 0 && !hold_i && !flush_i && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        if (flush_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                m_valid[k] = 0; m_wb[k] = 0; m_load[k] = 0; m_rd[k] = 0;
            end
        end else if (!hold_i) begin
            for (int k = DEPTH; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1]; m_wb[k] = m_wb[k-1];
                m_load[k]  = m_load[k-1];  m_rd[k] = m_rd[k-1];
            end
            if (issue_valid_i && exp_stall == 0) begin
                m_valid[1] = 1; m_wb[1] = int'(issue_wb_i);
                m_load[1]  = int'(issue_load_i); m_rd[1] = int'(issue_rd_i);
            end else begin
                m_valid[1] = 0; m_wb[1] = 0; m_load[1] = 0; m_rd[1] = 0;
            end
        end
    endtask

    // Compare DUT against model mid-cycle, then advance both at the edge.
    task automatic compare_outputs();
        model_eval();
        for (int s = 0; s < NUM_SRC; s++) begin
            obs_sel[s] = int'(sel_o[s*SEL_W +: SEL_W]);
            check($sformatf("sel%0d", s), obs_sel[s], exp_sel[s]);
        end
        obs_stall = int'(stall_o);
        check("stall", obs_stall, exp_stall);
`ifdef FWD_STALL_CNT_EN
        obs_cnt = longint'(stall_cnt_o);
        check("stall_cnt", obs_cnt, m_cnt);
`else
        obs_cnt = 0;
`endif
    endtask

    task automatic step(input logic v, input int rd, input logic wb, input logic ld,
                        input int rs0, input int rs1, input logic hold, input logic flush);
        issue_valid_i = v;
        issue_rd_i    = REG_W'(rd);
        issue_wb_i    = wb;
        issue_load_i  = ld;
        rs_i          = {REG_W'(rs1), REG_W'(rs0)};
        hold_i        = hold;
        flush_i       = flush;
        @(negedge clk_i);
        compare_outputs();
        @(posedge clk_i);
        model_advance();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0;
        issue_valid_i = 1'b0; issue_rd_i = '0; issue_wb_i = 1'b0; issue_load_i = 1'b0;
        rs_i = {REG_W'(2), REG_W'(1)}; hold_i = 1'b0; flush_i = 1'b0;
        model_reset();

        // Reset then idle
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        compare_outputs();
        check("reset_sel_lit", int'(sel_o), 0);
        check("reset_stall_lit", int'(stall_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
        check("idle_sel_lit", obs_sel[0] + obs_sel[1], 0);

        // ALU back-to-back
        step(1'b1, 5, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        check("alu_stage1_lit", obs_sel[0], 1);
        step(1'b0, 0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        check("alu_stage2_lit", obs_sel[0], 2);
        step(1'b0, 0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        check("alu_gone_lit", obs_sel[0], 0);

        // Double hazard: youngest wins
        step(1'b1, 3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);
        check("double_youngest_lit", obs_sel[1], 1);
        idle(2);

        // Load-use
        step(1'b1, 7, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b1, 10, 1'b1, 1'b0, 7, 0, 1'b0, 1'b0);
        check("lu_stall_lit", obs_stall, 1);
        check("lu_sel_lit", obs_sel[0], 1);
        step(1'b1, 10, 1'b1, 1'b0, 7, 0, 1'b0, 1'b0);
        check("lu_release_stall_lit", obs_stall, 0);
        check("lu_release_sel_lit", obs_sel[0], 2);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt_lit", obs_cnt, 1);
`endif
        // Consumer followed by the bubble: rd 10 should be in stage 1 now
        step(1'b0, 0, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0);
        check("lu_bubble_lit", obs_sel[0], 1);
        idle(2);

        // x0 and wb=0 never forward
        step(1'b1, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0);
        check("x0_wb0_sel_lit", obs_sel[0] + obs_sel[1], 0);
        check("x0_wb0_stall_lit", obs_stall, 0);
        idle(2);

        // Hold freezes a pending load-use, flush clears everything
        step(1'b1, 7, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 7, 0, 1'b1, 1'b0);
        check("hold_stall1_lit", obs_stall, 1);
        step(1'b0, 0, 1'b0, 1'b0, 7, 0, 1'b1, 1'b0);
        check("hold_stall2_lit", obs_stall, 1);
        check("hold_sel_lit", obs_sel[0], 1);
        step(1'b1, 9, 1'b1, 1'b0, 7, 0, 1'b0, 1'b1);
        check("flush_stall_lit", obs_stall, 0);
        step(1'b0, 0, 1'b0, 1'b0, 9, 7, 1'b0, 1'b0);
        check("post_flush_sel_lit", obs_sel[0] + obs_sel[1], 0);
`ifdef FWD_STALL_CNT_EN
        check("hold_no_cnt_lit", obs_cnt, 1);
`endif

        // Random traffic over a small register range to force frequent matches
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
